// File: rtl/fdiv_arbiter.sv
// Two-requester round-robin front end for a shared FP divider: grants one op at a time,
// drives the divider, aborts with a quiet NaN on timeout and returns the result by handshake.
module fdiv_arbiter #(
    parameter int TAGW    = 5,
    parameter int TIMEOUT = 40
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req0Valid_i,
    output logic            req0Ready_o,
    input  logic [31:0]     req0Rs1_i,
    input  logic [31:0]     req0Rs2_i,
    input  logic [2:0]      req0Rm_i,
    input  logic [TAGW-1:0] req0Tag_i,
    input  logic            req1Valid_i,
    output logic            req1Ready_o,
    input  logic [31:0]     req1Rs1_i,
    input  logic [31:0]     req1Rs2_i,
    input  logic [2:0]      req1Rm_i,
    input  logic [TAGW-1:0] req1Tag_i,
    output logic            divEnable_o,
    output logic [31:0]     divRs1_o,
    output logic [31:0]     divRs2_o,
    output logic [2:0]      divRm_o,
    input  logic            divReady_i,
    input  logic [31:0]     divResult_i,
    output logic            rspValid_o,
    input  logic            rspReady_i,
    output logic            rspId_o,
    output logic [TAGW-1:0] rspTag_o,
    output logic [31:0]     rspData_o,
    output logic            rspTimeout_o
);

    localparam logic [31:0] QNAN         = 32'h7FC0_0000;
    localparam logic [7:0]  TIMEOUT_LOAD = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        RESP
    } state_t;

    state_t          state_q;
    logic            lastGrant_q;
    logic [7:0]      count_q;
    logic            req0Ready_q;
    logic            req1Ready_q;
    logic            divEnable_q;
    logic [31:0]     divRs1_q;
    logic [31:0]     divRs2_q;
    logic [2:0]      divRm_q;
    logic            rspValid_q;
    logic            rspId_q;
    logic [TAGW-1:0] rspTag_q;
    logic [31:0]     rspData_q;
    logic            rspTimeout_q;

    logic            grantPending;
    logic            grantId_d;
    logic            xfer0;
    logic            xfer1;

    // On contention the requester that was not served last wins.
    always_comb begin
        grantPending = req0Valid_i || req1Valid_i;
        if (req0Valid_i && req1Valid_i) begin
            grantId_d = ~lastGrant_q;
        end else begin
            grantId_d = req1Valid_i;
        end
    end

    assign xfer0 = req0Ready_q && req0Valid_i;
    assign xfer1 = req1Ready_q && req1Valid_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            lastGrant_q  <= 1'b1;
            count_q      <= '0;
            req0Ready_q  <= 1'b0;
            req1Ready_q  <= 1'b0;
            divEnable_q  <= 1'b0;
            divRs1_q     <= '0;
            divRs2_q     <= '0;
            divRm_q      <= '0;
            rspValid_q   <= 1'b0;
            rspId_q      <= 1'b0;
            rspTag_q     <= '0;
            rspData_q    <= '0;
            rspTimeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Ready is a registered one-cycle pulse; the transfer lands on the edge closing it.
                    if (req0Ready_q || req1Ready_q) begin
                        req0Ready_q <= 1'b0;
                        req1Ready_q <= 1'b0;
                        if (xfer0 || xfer1) begin
                            divRs1_q    <= xfer1 ? req1Rs1_i : req0Rs1_i;
                            divRs2_q    <= xfer1 ? req1Rs2_i : req0Rs2_i;
                            divRm_q     <= xfer1 ? req1Rm_i  : req0Rm_i;
                            rspTag_q    <= xfer1 ? req1Tag_i : req0Tag_i;
                            rspId_q     <= xfer1;
                            lastGrant_q <= xfer1;
                            divEnable_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end else if (grantPending) begin
                        req0Ready_q <= ~grantId_d;
                        req1Ready_q <= grantId_d;
                    end
                end
                ISSUE: begin
                    count_q <= TIMEOUT_LOAD;
                    state_q <= WAIT;
                end
                WAIT: begin
                    count_q <= count_q - 8'd1;
                    if (divReady_i) begin
                        rspData_q    <= divResult_i;
                        rspTimeout_q <= 1'b0;
                        divEnable_q  <= 1'b0;
                        state_q      <= DRAIN;
                    end else if (count_q == 8'd1) begin
                        rspData_q    <= QNAN;
                        rspTimeout_q <= 1'b1;
                        divEnable_q  <= 1'b0;
                        state_q      <= DRAIN;
                    end
                end
                DRAIN: begin
                    rspValid_q <= 1'b1;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rspReady_i) begin
                        rspValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req0Ready_o  = req0Ready_q;
    assign req1Ready_o  = req1Ready_q;
    assign divEnable_o  = divEnable_q;
    assign divRs1_o     = divRs1_q;
    assign divRs2_o     = divRs2_q;
    assign divRm_o      = divRm_q;
    assign rspValid_o   = rspValid_q;
    assign rspId_o      = rspId_q;
    assign rspTag_o     = rspTag_q;
    assign rspData_o    = rspData_q;
    assign rspTimeout_o = rspTimeout_q;

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Self-checking bench for fdiv_arbiter: directed and randomized ops against a
// transaction-level model of arbitration, divider latency, timeout and response handshake.
module tb_fdiv_arbiter;

    localparam int          TAGW    = 5;
    localparam int          TIMEOUT = 40;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef struct {
        logic [31:0]     rs1;
        logic [31:0]     rs2;
        logic [2:0]      rm;
        logic [TAGW-1:0] tag;
        int              lat;
    } op_t;

    typedef struct {
        logic            id;
        logic [TAGW-1:0] tag;
        logic [31:0]     data;
        logic            to;
        int              lat;
    } rsp_t;

    logic            clk_i;
    logic            reset_i;
    logic            req0Valid_i, req1Valid_i;
    logic            req0Ready_o, req1Ready_o;
    logic [31:0]     req0Rs1_i, req0Rs2_i, req1Rs1_i, req1Rs2_i;
    logic [2:0]      req0Rm_i, req1Rm_i;
    logic [TAGW-1:0] req0Tag_i, req1Tag_i;
    logic            divEnable_o;
    logic [31:0]     divRs1_o, divRs2_o;
    logic [2:0]      divRm_o;
    logic            divReady_i;
    logic [31:0]     divResult_i;
    logic            rspValid_o;
    logic            rspReady_i;
    logic            rspId_o;
    logic [TAGW-1:0] rspTag_o;
    logic [31:0]     rspData_o;
    logic            rspTimeout_o;

    fdiv_arbiter #(.TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req0Valid_i(req0Valid_i), .req0Ready_o(req0Ready_o),
        .req0Rs1_i(req0Rs1_i), .req0Rs2_i(req0Rs2_i), .req0Rm_i(req0Rm_i), .req0Tag_i(req0Tag_i),
        .req1Valid_i(req1Valid_i), .req1Ready_o(req1Ready_o),
        .req1Rs1_i(req1Rs1_i), .req1Rs2_i(req1Rs2_i), .req1Rm_i(req1Rm_i), .req1Tag_i(req1Tag_i),
        .divEnable_o(divEnable_o), .divRs1_o(divRs1_o), .divRs2_o(divRs2_o), .divRm_o(divRm_o),
        .divReady_i(divReady_i), .divResult_i(divResult_i),
        .rspValid_o(rspValid_o), .rspReady_i(rspReady_i),
        .rspId_o(rspId_o), .rspTag_o(rspTag_o), .rspData_o(rspData_o), .rspTimeout_o(rspTimeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int              testsRun = 0;
    int              testsFailed = 0;
    int              cycleCount = 0;
    op_t             reqQ0[$];
    op_t             reqQ1[$];
    rsp_t            expQ[$];
    op_t             liveOp;
    bit              opLive = 0;
    logic            modelLast = 1'b1;
    int              enCycles = 0;
    logic            prevEnable = 1'b0;
    int              grantCycle = 0;
    int              rspSeen = 0;
    logic            shownId, shownTo;
    logic [TAGW-1:0] shownTag;
    logic [31:0]     shownData;
    logic [31:0]     lastData = '0;
    int              grantsSeen = 0;
    int              handshakes = 0;
    int              enableRises = 0;
    int              protoViol = 0;
    int              stabilityViol = 0;
    int              rspDelay = 0;
    bit              rspHoldHigh = 0;
    bit              strayPulses = 0;

    // Stand-in divider arithmetic; the one directed case returns the true quotient 6.0/2.0.
    function automatic logic [31:0] divFunc(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic driveRequesters();
        req0Valid_i = (reqQ0.size() > 0);
        if (req0Valid_i) begin
            req0Rs1_i = reqQ0[0].rs1; req0Rs2_i = reqQ0[0].rs2;
            req0Rm_i  = reqQ0[0].rm;  req0Tag_i = reqQ0[0].tag;
        end
        req1Valid_i = (reqQ1.size() > 0);
        if (req1Valid_i) begin
            req1Rs1_i = reqQ1[0].rs1; req1Rs2_i = reqQ1[0].rs2;
            req1Rm_i  = reqQ1[0].rm;  req1Tag_i = reqQ1[0].tag;
        end
    endtask

    // One clock: observe everything at the falling edge, then drive inputs just after the rising edge.
    task automatic applyStimulus();
        rsp_t e;
        logic gid, expId;
        @(negedge clk_i);
        cycleCount++;
        if (req0Ready_o && req1Ready_o) protoViol++;
        if ((req0Ready_o || req1Ready_o) && (divEnable_o || rspValid_o)) protoViol++;
        if (divEnable_o && !prevEnable) begin
            enableRises++;
            if (opLive) begin
                checkOutput("divRs1", divRs1_o, liveOp.rs1);
                checkOutput("divRs2", divRs2_o, liveOp.rs2);
                checkOutput("divRm", 32'(divRm_o), 32'(liveOp.rm));
            end
        end else if (divEnable_o && opLive) begin
            if (divRs1_o !== liveOp.rs1 || divRs2_o !== liveOp.rs2 || divRm_o !== liveOp.rm) stabilityViol++;
        end
        prevEnable = divEnable_o;
        if ((req0Valid_i && req0Ready_o) || (req1Valid_i && req1Ready_o)) begin
            gid   = req1Valid_i && req1Ready_o;
            expId = (req0Valid_i && req1Valid_i) ? ~modelLast : req1Valid_i;
            checkOutput("grantId", 32'(gid), 32'(expId));
            modelLast = expId;
            liveOp = gid ? reqQ1.pop_front() : reqQ0.pop_front();
            opLive = 1;
            grantsSeen++;
            grantCycle = cycleCount;
            e.id  = expId;
            e.tag = liveOp.tag;
            if (liveOp.lat >= 2 && liveOp.lat <= TIMEOUT + 1) begin
                e.data = divFunc(liveOp.rs1, liveOp.rs2); e.to = 1'b0; e.lat = liveOp.lat;
            end else begin
                e.data = QNAN; e.to = 1'b1; e.lat = TIMEOUT + 1;
            end
            expQ.push_back(e);
        end
        if (rspValid_o) begin
            if (rspSeen == 0) begin
                shownId = rspId_o; shownTag = rspTag_o; shownData = rspData_o; shownTo = rspTimeout_o;
                checkOutput("rspExpected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) checkOutput("rspLatency", 32'(cycleCount - grantCycle), 32'(expQ[0].lat + 2));
            end else if (rspId_o !== shownId || rspTag_o !== shownTag || rspData_o !== shownData || rspTimeout_o !== shownTo) begin
                stabilityViol++;
            end
            rspSeen++;
            if (rspReady_i) begin
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("rspId", 32'(rspId_o), 32'(e.id));
                    checkOutput("rspTag", 32'(rspTag_o), 32'(e.tag));
                    checkOutput("rspData", rspData_o, e.data);
                    checkOutput("rspTimeout", 32'(rspTimeout_o), 32'(e.to));
                end
                lastData = rspData_o;
                handshakes++;
                rspSeen = 0;
                opLive = 0;
            end
        end
        @(posedge clk_i);
        #1;
        if (divEnable_o) enCycles++; else enCycles = 0;
        if (divEnable_o && opLive && liveOp.lat > 0 && enCycles == liveOp.lat) begin
            divReady_i = 1'b1; divResult_i = divFunc(divRs1_o, divRs2_o);
        end else if (strayPulses && !divEnable_o && $urandom_range(0, 3) == 0) begin
            divReady_i = 1'b1; divResult_i = $urandom;
        end else begin
            divReady_i = 1'b0; divResult_i = 32'hDEAD_BEEF;
        end
        driveRequesters();
        rspReady_i = rspHoldHigh || (rspValid_o && rspSeen >= rspDelay);
    endtask

    task automatic runUntilDone(input string name, input int budget);
        int n = 0;
        while ((reqQ0.size() > 0 || reqQ1.size() > 0 || opLive || expQ.size() > 0) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(name, 32'(reqQ0.size() > 0 || reqQ1.size() > 0 || opLive || expQ.size() > 0), 32'd0);
    endtask

    function automatic op_t randOp(input logic [TAGW-1:0] tag, input int lat);
        op_t o;
        o.rs1 = $urandom; o.rs2 = $urandom; o.rm = 3'($urandom_range(0, 4)); o.tag = tag; o.lat = lat;
        return o;
    endfunction

    function automatic int randLat();
        int pick = $urandom_range(0, 9);
        if (pick == 0) return 0;
        if (pick == 1) return TIMEOUT + 1;
        if (pick == 2) return TIMEOUT + 2;
        return $urandom_range(2, 30);
    endfunction

    initial begin
        op_t o;
        int g0, r0;
        reset_i = 1'b0;
        req0Valid_i = 0; req1Valid_i = 0;
        req0Rs1_i = '0; req0Rs2_i = '0; req0Rm_i = '0; req0Tag_i = '0;
        req1Rs1_i = '0; req1Rs2_i = '0; req1Rm_i = '0; req1Tag_i = '0;
        divReady_i = 0; divResult_i = '0; rspReady_i = 0;

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("rstReq0Ready", 32'(req0Ready_o), 0);
        checkOutput("rstReq1Ready", 32'(req1Ready_o), 0);
        checkOutput("rstDivEnable", 32'(divEnable_o), 0);
        checkOutput("rstRspValid", 32'(rspValid_o), 0);
        checkOutput("rstRspId", 32'(rspId_o), 0);
        checkOutput("rstRspTag", 32'(rspTag_o), 0);
        checkOutput("rstRspData", rspData_o, 0);
        checkOutput("rstRspTimeout", 32'(rspTimeout_o), 0);
        checkOutput("rstDivRs1", divRs1_o, 0);
        checkOutput("rstDivRs2", divRs2_o, 0);
        checkOutput("rstDivRm", 32'(divRm_o), 0);
        reset_i = 1'b1;

        // Single directed divide 6.0 / 2.0.
        rspHoldHigh = 1;
        o.rs1 = 32'h40C0_0000; o.rs2 = 32'h4000_0000; o.rm = 3'd0; o.tag = 5'd3; o.lat = 29;
        reqQ0.push_back(o);
        driveRequesters();
        runUntilDone("singleDone", 200);
        checkOutput("singleData", lastData, 32'h4040_0000);

        // Contention: both requesters hold valid for four ops each.
        rspHoldHigh = 0; rspDelay = 0;
        g0 = grantsSeen; r0 = enableRises;
        for (int i = 0; i < 4; i++) begin
            reqQ0.push_back(randOp(5'(i), $urandom_range(2, 30)));
            reqQ1.push_back(randOp(5'(16 + i), $urandom_range(2, 30)));
        end
        driveRequesters();
        runUntilDone("contentionDone", 1000);
        checkOutput("contentionGrants", 32'(grantsSeen - g0), 32'd8);
        checkOutput("contentionEnableRuns", 32'(enableRises - r0), 32'd8);

        // Back-pressure: ten cycles of rspReady low with another request waiting.
        rspDelay = 10;
        reqQ1.push_back(randOp(5'd9, 12));
        reqQ0.push_back(randOp(5'd10, 7));
        driveRequesters();
        runUntilDone("backpressureDone", 400);
        checkOutput("backpressureStable", 32'(stabilityViol), 0);
        rspDelay = 0;

        // Timeout: never ready, ready on the expiry cycle, ready one cycle too late.
        reqQ0.push_back(randOp(5'd11, 0));
        reqQ1.push_back(randOp(5'd12, TIMEOUT + 1));
        reqQ0.push_back(randOp(5'd13, TIMEOUT + 2));
        driveRequesters();
        runUntilDone("timeoutDone", 400);

        // Randomized traffic with stray divider pulses and varying back-pressure.
        strayPulses = 1;
        for (int b = 0; b < 4; b++) begin
            rspDelay = $urandom_range(0, 3);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 1) == 1) reqQ1.push_back(randOp(5'($urandom), randLat()));
                else reqQ0.push_back(randOp(5'($urandom), randLat()));
            end
            driveRequesters();
            runUntilDone("randomDone", 800);
        end
        strayPulses = 0; rspDelay = 0;

        // Reset in the middle of WAIT discards the op; a lone req1 then completes.
        reqQ0.push_back(randOp(5'd21, 0));
        driveRequesters();
        repeat (12) applyStimulus();
        #3;
        reset_i = 1'b0;
        #1;
        checkOutput("midRstDivEnable", 32'(divEnable_o), 0);
        checkOutput("midRstRspValid", 32'(rspValid_o), 0);
        checkOutput("midRstReady", 32'(req0Ready_o | req1Ready_o), 0);
        reqQ0.delete(); expQ.delete(); opLive = 0; rspSeen = 0; modelLast = 1'b1;
        driveRequesters();
        repeat (2) applyStimulus();
        checkOutput("midRstRspData", rspData_o, 0);
        checkOutput("midRstDivRs1", divRs1_o, 0);
        r0 = handshakes;
        reqQ1.push_back(randOp(5'd22, 15));
        driveRequesters();
        reset_i = 1'b1;
        g0 = grantsSeen;
        applyStimulus();
        applyStimulus();
        checkOutput("postRstFirstGrant", 32'(grantsSeen - g0), 32'd1);
        runUntilDone("postRstDone", 200);
        checkOutput("postRstOneResponse", 32'(handshakes - r0), 32'd1);

        checkOutput("protocolViolations", 32'(protoViol), 0);
        checkOutput("stabilityViolations", 32'(stabilityViol), 0);
        checkOutput("grantsEqualResponses", 32'(grantsSeen - 1), 32'(handshakes));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
